// File: rtl/spi_rx_packer_pkg.sv
// spi_rx_packer_pkg: shared SPI lane-mode/size encodings and receive FSM states
package spi_rx_packer_pkg;
  localparam logic [1:0] SPI_STD_SPI  = 2'b00;
  localparam logic [1:0] SPI_DUAL_SPI = 2'b01;
  localparam logic [1:0] SPI_QUAD_SPI = 2'b10;
  localparam logic [1:0] SPI_SIZE_8   = 2'd0;
  localparam logic [1:0] SPI_SIZE_16  = 2'd1;
  localparam logic [1:0] SPI_SIZE_24  = 2'd2;
  localparam logic [1:0] SPI_SIZE_32  = 2'd3;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} rx_state_e;
endpackage

// File: rtl/spi_dff.sv
// spi_dff: flop with synchronous active-low reset to RST
// ports: clk_i clock, rst_n_i sync reset, d_i next value, q_o registered value
module spi_dff #(
  parameter int W = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  always_ff @(posedge clk_i)
    q_o <= !rst_n_i ? RST : d_i;
endmodule

// File: rtl/spi_rx_shifter.sv
// spi_rx_shifter: SPI receive lane select, bit ordering and word bit counter
// ports: clk_i/rst_n_i clock and sync reset; clr_i discard partial word; ld_i latch
//        dmode_i/dsize_i/lsb_i; smp_i capture one lane group; flush_i push partial;
//        io_i pads; done_o word ready this cycle on word_o; busy_o bit count nonzero
module spi_rx_shifter
  import spi_rx_packer_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        clr_i,
  input  logic        ld_i,
  input  logic [1:0]  dmode_i,
  input  logic [1:0]  dsize_i,
  input  logic        lsb_i,
  input  logic        smp_i,
  input  logic        flush_i,
  input  logic [3:0]  io_i,
  output logic        done_o,
  output logic [31:0] word_o,
  output logic        busy_o
);
  logic [1:0]  r_mode, r_size;
  logic        r_lsb;
  logic [5:0]  r_cnt;
  logic [31:0] r_sr;
  logic [5:0]  w_step, w_width, w_cnt_n;
  logic [3:0]  w_bits;
  logic [31:0] w_sr_n;
  logic        w_done;
  always_comb begin
    w_step  = r_mode == SPI_QUAD_SPI ? 6'd4 : r_mode == SPI_DUAL_SPI ? 6'd2 : 6'd1;
    w_bits  = r_mode == SPI_QUAD_SPI ? io_i : r_mode == SPI_DUAL_SPI ? {2'b0, io_i[1:0]} : {3'b0, io_i[1]};
    w_width = {1'b0, r_size, 3'b0} + 6'd8;
    w_cnt_n = r_cnt + (smp_i ? w_step : 6'd0);
    // both orders keep the word right-aligned because the register starts each word at zero
    w_sr_n  = !smp_i ? r_sr : r_lsb ? r_sr | ({28'b0, w_bits} << r_cnt) : (r_sr << w_step) | {28'b0, w_bits};
    w_done  = !clr_i && ((smp_i && w_cnt_n == w_width) || (flush_i && w_cnt_n != 6'd0));
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_mode <= SPI_STD_SPI;
      r_size <= SPI_SIZE_8;
      r_lsb  <= 1'b0;
      r_cnt  <= '0;
      r_sr   <= '0;
    end else begin
      if (ld_i) begin
        r_mode <= dmode_i;
        r_size <= dsize_i;
        r_lsb  <= lsb_i;
      end
      r_cnt <= (clr_i || w_done) ? 6'd0 : w_cnt_n;
      r_sr  <= (clr_i || w_done) ? 32'd0 : w_sr_n;
    end
  end
  assign done_o = w_done;
  assign word_o = w_sr_n;
  assign busy_o = r_cnt != 6'd0;
endmodule

// File: rtl/spi_rx_packer.sv
// spi_rx_packer: packs SPI read-phase samples into 8..32-bit words on a valid/ready stream
// ports: clk_i/rst_n_i clock and sync active-low reset; en_i receive window; smp_i sample
//        pulse; clr_i abort; flush_i push partial; dmode_i/dsize_i/lsb_i format;
//        spi_io_in_i pads; rx_valid_o/rx_ready_i/rx_data_o output stream; busy_o; ovf_o
// SPI_RX_OVF_EN: when defined ovf_o is a sticky overflow flag, otherwise tied 0
module spi_rx_packer
  import spi_rx_packer_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  input  logic        smp_i,
  input  logic        clr_i,
  input  logic        flush_i,
  input  logic [1:0]  dmode_i,
  input  logic [1:0]  dsize_i,
  input  logic        lsb_i,
  input  logic [3:0]  spi_io_in_i,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic [31:0] rx_data_o,
  output logic        busy_o,
  output logic        ovf_o
);
  rx_state_e   w_state_n;
  logic        r_state;
  logic        r_valid;
  logic [31:0] r_data;
  logic        w_run, w_ld, w_sclr, w_space, w_done;
  logic [31:0] w_word;
  spi_dff #(.W(1), .RST(ST_IDLE)) u_state (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(w_state_n), .q_o(r_state)
  );
  always_comb begin
    w_state_n = (!clr_i && en_i) ? ST_RUN : ST_IDLE;
    w_run     = r_state == ST_RUN;
    w_ld      = !w_run && en_i && !clr_i;
    // leaving the window mid-word discards the partial word like an abort
    w_sclr    = clr_i || (w_run && !en_i);
    w_space   = !r_valid || rx_ready_i;
  end
  spi_rx_shifter u_shift (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .clr_i(w_sclr), .ld_i(w_ld),
    .dmode_i(dmode_i), .dsize_i(dsize_i), .lsb_i(lsb_i),
    .smp_i(smp_i && w_run), .flush_i(flush_i && w_run), .io_i(spi_io_in_i),
    .done_o(w_done), .word_o(w_word), .busy_o(busy_o)
  );
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (clr_i) begin
      r_valid <= 1'b0;
    end else if (w_done && w_space) begin
      r_valid <= 1'b1;
      r_data  <= w_word;
    end else if (rx_ready_i) begin
      r_valid <= 1'b0;
    end
  end
  assign rx_valid_o = r_valid;
  assign rx_data_o  = r_data;
`ifdef SPI_RX_OVF_EN
  logic r_ovf;
  always_ff @(posedge clk_i)
    r_ovf <= !rst_n_i ? 1'b0 : (clr_i && !w_run) ? 1'b0 : (w_done && !w_space) ? 1'b1 : r_ovf;
  assign ovf_o = r_ovf;
`else
  assign ovf_o = 1'b0;
`endif
endmodule

// File: tb/tb_spi_rx_packer.sv
// tb_spi_rx_packer: directed scoreboard bench for spi_rx_packer
module tb_spi_rx_packer;
  logic        clk_i = 1'b0, rst_n_i, en_i, smp_i, clr_i, flush_i, lsb_i, rx_ready_i;
  logic [1:0]  dmode_i, dsize_i;
  logic [3:0]  spi_io_in_i;
  logic        rx_valid_o, busy_o, ovf_o;
  logic [31:0] rx_data_o;
  logic [31:0] q[$];
  int          n_tot = 0, n_bad = 0;
`ifdef SPI_RX_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif
  spi_rx_packer dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .smp_i(smp_i), .clr_i(clr_i),
    .flush_i(flush_i), .dmode_i(dmode_i), .dsize_i(dsize_i), .lsb_i(lsb_i),
    .spi_io_in_i(spi_io_in_i), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .rx_data_o(rx_data_o), .busy_o(busy_o), .ovf_o(ovf_o)
  );
  always #5 clk_i = ~clk_i;
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk_i)
    if (rst_n_i && rx_valid_o && rx_ready_i) begin
      if (q.size() == 0) chk("unexpected_word", rx_data_o, 32'hxxxxxxxx);
      else chk("word", rx_data_o, q.pop_front());
    end
  function automatic logic [3:0] sio(input logic b);
    return {~b, ~b, b, ~b};
  endfunction
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask
  task automatic smp(input logic [3:0] io);
    spi_io_in_i = io;
    smp_i = 1'b1;
    cyc();
    smp_i = 1'b0;
  endtask
  task automatic sbits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) smp(sio(v[i]));
  endtask
  task automatic start(input logic [1:0] m, input logic [1:0] s, input logic l);
    dmode_i = m;
    dsize_i = s;
    lsb_i = l;
    en_i = 1'b1;
    cyc();
    dmode_i = ~m;
    dsize_i = ~s;
    lsb_i = ~l;
  endtask
  task automatic stop();
    en_i = 1'b0;
    cyc();
  endtask
  initial begin
    {en_i, smp_i, clr_i, flush_i, lsb_i, dmode_i, dsize_i, spi_io_in_i} = '0;
    rx_ready_i = 1'b1;
    rst_n_i = 1'b0;
    cyc();
    cyc();
    chk("rst_valid", rx_valid_o, 0);
    chk("rst_data", rx_data_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ovf", ovf_o, 0);
    rst_n_i = 1'b1;
    cyc();
    start(2'b00, 2'd0, 1'b0);
    q.push_back(32'h000000A5);
    sbits(32'h5, 3);
    chk("std8_busy", busy_o, 1);
    sbits(32'h05, 5);
    chk("std8_valid", rx_valid_o, 1);
    chk("std8_busy_end", busy_o, 0);
    stop();
    start(2'b10, 2'd3, 1'b1);
    q.push_back(32'h87654321);
    for (int k = 1; k <= 8; k++) smp(4'(k));
    stop();
    start(2'b10, 2'd0, 1'b0);
    q.push_back(32'h000000A5);
    smp(4'hA);
    smp(4'h5);
    stop();
    start(2'b01, 2'd0, 1'b0);
    q.push_back(32'h0000009C);
    smp(4'b1110); smp(4'b1101); smp(4'b1111); smp(4'b1100);
    stop();
    start(2'b01, 2'd0, 1'b1);
    q.push_back(32'h0000009C);
    smp(4'b1000); smp(4'b1011); smp(4'b1001); smp(4'b1010);
    stop();
    rx_ready_i = 1'b0;
    start(2'b01, 2'd1, 1'b0);
    smp(4'b1101); smp(4'b1110); smp(4'b1111); smp(4'b1100);
    smp(4'b1100); smp(4'b1111); smp(4'b1110); smp(4'b1101);
    chk("dual16_valid", rx_valid_o, 1);
    chk("dual16_data", rx_data_o, 32'h00006C39);
    for (int k = 0; k < 8; k++) smp(4'b0011);
    chk("dual16_hold", rx_data_o, 32'h00006C39);
    chk("dual16_ovf", ovf_o, 32'(OVF_EXP));
    q.push_back(32'h00006C39);
    rx_ready_i = 1'b1;
    cyc();
    chk("dual16_lost", rx_valid_o, 0);
    stop();
    chk("ovf_sticky", ovf_o, 32'(OVF_EXP));
    clr_i = 1'b1;
    cyc();
    clr_i = 1'b0;
    chk("ovf_clr", ovf_o, 0);
    start(2'b00, 2'd2, 1'b0);
    q.push_back(32'h0000032D);
    sbits(32'h32D, 10);
    chk("flush_busy_pre", busy_o, 1);
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    chk("flush_busy", busy_o, 0);
    chk("flush_valid", rx_valid_o, 1);
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    cyc();
    chk("flush_empty", rx_valid_o, 0);
    stop();
    start(2'b00, 2'd0, 1'b1);
    q.push_back(32'h0000000D);
    smp(sio(1'b1));
    smp(sio(1'b0));
    smp(sio(1'b1));
    flush_i = 1'b1;
    smp(sio(1'b1));
    flush_i = 1'b0;
    stop();
    start(2'b00, 2'd0, 1'b0);
    sbits(32'h52, 7);
    clr_i = 1'b1;
    smp(sio(1'b1));
    clr_i = 1'b0;
    chk("clr_valid", rx_valid_o, 0);
    chk("clr_busy", busy_o, 0);
    smp(sio(1'b1));
    chk("clr_idle", busy_o, 0);
    stop();
    start(2'b00, 2'd0, 1'b0);
    sbits(32'h5, 3);
    stop();
    chk("enfall_busy", busy_o, 0);
    chk("enfall_ovf", ovf_o, 0);
    start(2'b00, 2'd0, 1'b0);
    q.push_back(32'h000000A5);
    sbits(32'hA5, 8);
    stop();
    rx_ready_i = 1'b0;
    start(2'b00, 2'd0, 1'b0);
    sbits(32'h3C, 8);
    chk("rstmid_valid_pre", rx_valid_o, 1);
    sbits(32'h5, 3);
    chk("rstmid_busy_pre", busy_o, 1);
    rst_n_i = 1'b0;
    smp_i = 1'b1;
    flush_i = 1'b1;
    cyc();
    chk("rstmid_valid", rx_valid_o, 0);
    chk("rstmid_data", rx_data_o, 0);
    chk("rstmid_busy", busy_o, 0);
    chk("rstmid_ovf", ovf_o, 0);
    rst_n_i = 1'b1;
    smp_i = 1'b0;
    flush_i = 1'b0;
    en_i = 1'b0;
    rx_ready_i = 1'b1;
    cyc();
    start(2'b00, 2'd0, 1'b0);
    q.push_back(32'h0000005A);
    sbits(32'h5A, 8);
    stop();
    for (int k = 0; k < 20 && q.size() != 0; k++) cyc();
    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
